// File: rtl/fault_mcast_injector.sv
// Local-port injection stage: stamps source coordinates and, when a fault is present,
// expands multicast/broadcast packets into a unicast sequence that skips the faulty node.
module fault_mcast_injector #(
    parameter logic [2:0]  LOCAL_X = 3'd0,
    parameter logic [2:0]  LOCAL_Y = 3'd0,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_pkt_type,
    input  logic [2:0]        in_tgt_x,
    input  logic [2:0]        in_tgt_y,
    input  logic [DATA_W-1:0] in_data,
    input  logic              pg_en,
    input  logic [2:0]        pg_node_x,
    input  logic [2:0]        pg_node_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_pkt_type,
    output logic [2:0]        out_src_x,
    output logic [2:0]        out_src_y,
    output logic [2:0]        out_tgt_x,
    output logic [2:0]        out_tgt_y,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              drop_pulse
);

    typedef enum logic [1:0] {StIdle, StPass, StExpand} state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d, last_q, last_d, drop_q, drop_d;
    logic [1:0]          type_q, type_d, mtype_q, mtype_d;
    logic [2:0]          src_x_q, src_x_d, src_y_q, src_y_d;
    logic [2:0]          tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [2:0]          fx_q, fx_d, fy_q, fy_d;
    logic [DATA_W-1:0]   data_q, data_d;

    // Position encoding is {y, x}; step walks column, row or raster order.
    function automatic logic [5:0] step(input logic [1:0] t, input logic [2:0] x,
                                        input logic [2:0] y);
        case (t)
            2'b01:   return {y + 3'd1, x};
            2'b10:   return {y, x + 3'd1};
            default: return (x == 3'd7) ? {y + 3'd1, 3'd0} : {y, x + 3'd1};
        endcase
    endfunction

    function automatic logic at_end(input logic [1:0] t, input logic [2:0] x,
                                    input logic [2:0] y);
        case (t)
            2'b01:   return y == 3'd7;
            2'b10:   return x == 3'd7;
            default: return (x == 3'd7) && (y == 3'd7);
        endcase
    endfunction

    // Last if at end of sequence, or if only the faulty node remains after it.
    function automatic logic is_last(input logic [1:0] t, input logic [2:0] x,
                                     input logic [2:0] y, input logic [2:0] fx,
                                     input logic [2:0] fy);
        logic [5:0] n;
        n = step(t, x, y);
        return at_end(t, x, y) || ((n == {fy, fx}) && at_end(t, n[2:0], n[5:3]));
    endfunction

    logic       accept, drop_in, expand_in;
    logic [2:0] org_x, org_y;
    logic [5:0] first_pos, p1, next_pos;

    assign in_ready  = !valid_q || (out_ready && last_q);
    assign accept    = in_valid && in_ready;
    assign drop_in   = pg_en && (in_pkt_type == 2'b00) &&
                       (in_tgt_x == pg_node_x) && (in_tgt_y == pg_node_y);
    assign expand_in = pg_en && (in_pkt_type != 2'b00);

    assign org_x     = (in_pkt_type == 2'b01) ? in_tgt_x : 3'd0;
    assign org_y     = (in_pkt_type == 2'b10) ? in_tgt_y : 3'd0;
    assign first_pos = ({org_y, org_x} == {pg_node_y, pg_node_x}) ?
                       step(in_pkt_type, org_x, org_y) : {org_y, org_x};
    assign p1        = step(mtype_q, tgt_x_q, tgt_y_q);
    assign next_pos  = (p1 == {fy_q, fx_q}) ? step(mtype_q, p1[2:0], p1[5:3]) : p1;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        drop_d  = 1'b0;
        type_d  = type_q;
        mtype_d = mtype_q;
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        data_d  = data_q;
        if (accept) begin
            if (drop_in) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                drop_d  = 1'b1;
                state_d = StIdle;
            end else begin
                valid_d = 1'b1;
                src_x_d = LOCAL_X;
                src_y_d = LOCAL_Y;
                data_d  = in_data;
                if (expand_in) begin
                    type_d  = 2'b00;
                    tgt_x_d = first_pos[2:0];
                    tgt_y_d = first_pos[5:3];
                    last_d  = is_last(in_pkt_type, first_pos[2:0], first_pos[5:3],
                                      pg_node_x, pg_node_y);
                    mtype_d = in_pkt_type;
                    fx_d    = pg_node_x;
                    fy_d    = pg_node_y;
                    state_d = StExpand;
                end else begin
                    type_d  = in_pkt_type;
                    tgt_x_d = in_tgt_x;
                    tgt_y_d = in_tgt_y;
                    last_d  = 1'b1;
                    state_d = StPass;
                end
            end
        end else if (valid_q && out_ready) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = StIdle;
            end else if (state_q == StExpand) begin
                tgt_x_d = next_pos[2:0];
                tgt_y_d = next_pos[5:3];
                last_d  = is_last(mtype_q, next_pos[2:0], next_pos[5:3], fx_q, fy_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
            type_q  <= 2'b00;
            mtype_q <= 2'b00;
            src_x_q <= 3'd0;
            src_y_q <= 3'd0;
            tgt_x_q <= 3'd0;
            tgt_y_q <= 3'd0;
            fx_q    <= 3'd0;
            fy_q    <= 3'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            type_q  <= type_d;
            mtype_q <= mtype_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            data_q  <= data_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_last     = last_q;
    assign drop_pulse   = drop_q;
    assign out_pkt_type = type_q;
    assign out_src_x    = src_x_q;
    assign out_src_y    = src_y_q;
    assign out_tgt_x    = tgt_x_q;
    assign out_tgt_y    = tgt_y_q;
    assign out_data     = data_q;

endmodule
